// File: rtl/arb_out_queue_pkg.sv
// arb_out_queue_pkg: shared defaults and entry layout for the arbiter output queue.
// Optional feature macro: ARB_OUT_QUEUE_FLOW_EN (empty-queue bypass, used by arb_out_queue).
package arb_out_queue_pkg;

  localparam int unsigned ARB_OQ_DEPTH = 4;
  localparam int unsigned ARB_OQ_WIDTH = 8;
  localparam int unsigned ARB_OQ_SRC_W = 2;

  // Default-width entry: source tag in the upper bits, payload below.
  typedef struct packed {
    logic [ARB_OQ_SRC_W-1:0] src;
    logic [ARB_OQ_WIDTH-1:0] data;
  } arb_oq_entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned arb_oq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arb_out_queue_ram.sv
// arb_out_queue_ram: DEPTH x ENTRY_W storage, one synchronous write port,
// one asynchronous read port, asynchronous active-low clear of every word.
module arb_out_queue_ram
  import arb_out_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = ARB_OQ_DEPTH,
  parameter int unsigned ENTRY_W = ARB_OQ_SRC_W + ARB_OQ_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  // Next storage contents: hold, or overwrite the addressed word on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/arb_out_queue.sv
// arb_out_queue: FIFO placed after an arbiter; carries each payload together with
// the grant index that produced it. Strict FIFO order, ready/valid on both sides.
// Optional macro ARB_OUT_QUEUE_FLOW_EN: when the queue is empty, an incoming entry
// is presented at the head combinationally and, if taken the same cycle, never stored.
module arb_out_queue
  import arb_out_queue_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_OQ_DEPTH,
  parameter int unsigned WIDTH = ARB_OQ_WIDTH,
  parameter int unsigned SRC_W = ARB_OQ_SRC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_enq_valid,
  output logic                     io_enq_ready,
  input  logic [WIDTH-1:0]         io_enq_bits,
  input  logic [SRC_W-1:0]         io_enq_chosen,
  output logic                     io_deq_valid,
  input  logic                     io_deq_ready,
  output logic [WIDTH-1:0]         io_deq_bits,
  output logic [SRC_W-1:0]         io_deq_chosen,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = arb_oq_cnt_w(DEPTH);
  localparam int unsigned ENTRY_W = SRC_W + WIDTH;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
  logic             maybe_full_q, maybe_full_d;

  logic             ptr_match, empty, full;
  logic             enq_fire, deq_fire;
  logic             do_enq, do_deq;
  logic [PTR_W-1:0] ptr_diff;
  entry_t           wr_entry, rd_entry, head_entry;
  logic [ENTRY_W-1:0] rd_raw;

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match &  maybe_full_q;

  assign wr_entry  = '{src: io_enq_chosen, data: io_enq_bits};
  assign rd_entry  = entry_t'(rd_raw);

  arb_out_queue_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (do_enq),
    .waddr (enq_ptr_q),
    .wdata (wr_entry),
    .raddr (deq_ptr_q),
    .rdata (rd_raw)
  );

  // Handshake, head selection and which fires actually touch storage.
  always_comb begin
    io_enq_ready = ~full;
    enq_fire     = io_enq_valid & io_enq_ready;
`ifdef ARB_OUT_QUEUE_FLOW_EN
    // Bypass: an empty queue forwards the enq side; a same-cycle take consumes it
    // without a write, and the deq fire does not move deq_ptr past an empty slot.
    io_deq_valid = ~empty | io_enq_valid;
    head_entry   = empty ? wr_entry : rd_entry;
    deq_fire     = io_deq_valid & io_deq_ready;
    do_enq       = enq_fire & ~(empty & io_deq_ready);
    do_deq       = deq_fire & ~empty;
`else
    io_deq_valid = ~empty;
    head_entry   = rd_entry;
    deq_fire     = io_deq_valid & io_deq_ready;
    do_enq       = enq_fire;
    do_deq       = deq_fire;
`endif
    io_deq_bits   = head_entry.data;
    io_deq_chosen = head_entry.src;
  end

  // Pointer advance and full/empty disambiguation flag.
  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) begin
      enq_ptr_d = enq_ptr_q + PTR_W'(1);
    end
    if (do_deq) begin
      deq_ptr_d = deq_ptr_q + PTR_W'(1);
    end
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Occupancy from pointer distance; when full the distance wraps to zero and the
  // top bit alone encodes DEPTH.
  always_comb begin
    ptr_diff = enq_ptr_q - deq_ptr_q;
    io_count = CNT_W'({full, ptr_diff});
  end

endmodule

// File: doc/arb_out_queue.md
ARB_OUT_QUEUE -- requirements
Module: arb_out_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, 4, number of entries (power of two, >= 2).
REQ-002 The block SHALL have parameter WIDTH, 8, payload width in bits.
REQ-003 The block SHALL have parameter SRC_W, 2, width of the source-index tag.
REQ-004 The block SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port io_enq_valid  in  1  upstream (arbiter output) has data.
REQ-007 The block SHALL have port io_enq_ready  out  1  queue accepts an entry this cycle.
REQ-008 The block SHALL have port io_enq_bits  in  WIDTH  payload from arbiter.
REQ-009 The block SHALL have port io_enq_chosen  in  SRC_W  arbiter grant index for the payload.
REQ-010 The block SHALL have port io_deq_valid  out  1  queue head is valid.
REQ-011 The block SHALL have port io_deq_ready  in  1  consumer takes head this cycle.
REQ-012 The block SHALL have port io_deq_bits  out  WIDTH  head payload.
REQ-013 The block SHALL have port io_deq_chosen  out  SRC_W  head source index.
REQ-014 The block SHALL have port io_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Enqueue fire = io_enq_valid & io_enq_ready; the entry {chosen, bits} SHALL be written at enq_ptr on that rising edge.
REQ-016 Dequeue fire = io_deq_valid & io_deq_ready; deq_ptr SHALL advance on that rising edge.
REQ-017 io_enq_ready SHALL be !full, registered-state only; it SHALL NOT depend on io_deq_ready.
REQ-018 io_deq_valid SHALL be !empty; io_deq_bits/io_deq_chosen SHALL be the entry at deq_ptr (combinational read, zero added latency beyond one cycle enqueue-to-head).
REQ-019 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; full/empty SHALL be disambiguated by a maybe_full flag (set on enq-only, cleared on deq-only).
REQ-020 Simultaneous enq and deq fire SHALL leave io_count and maybe_full unchanged and advance both pointers.
REQ-021 When full, io_enq_valid SHALL be ignored; when empty (flow disabled), io_deq_ready SHALL have no effect.
REQ-022 Entry order SHALL be strict FIFO; io_deq_chosen SHALL always accompany the payload it was enqueued with.
REQ-023 io_count SHALL equal enq fires minus deq fires since reset, never exceeding DEPTH nor below 0.

Reset
REQ-024 On reset low, pointers, maybe_full and storage SHALL clear asynchronously: io_enq_ready=1, io_deq_valid=0, io_deq_bits=0, io_deq_chosen=0, io_count=0.
REQ-025 Reset asserted mid-transfer SHALL discard all entries; first post-release edge SHALL behave as empty queue.

Configuration
REQ-026 Macro ARB_OUT_QUEUE_FLOW_EN defined: when empty and io_enq_valid=1, io_deq_valid SHALL be 1 with io_deq_bits/io_deq_chosen driven from enq inputs; if io_deq_ready=1 same cycle, nothing is stored and count stays 0.
REQ-027 Macro undefined: no bypass path; empty queue always yields io_deq_valid=0, minimum enqueue-to-dequeue latency one cycle.

Structure
REQ-028 Package arb_out_queue_pkg SHALL hold DEPTH/WIDTH/SRC_W defaults and the entry typedef {src[SRC_W], data[WIDTH]}.
REQ-029 Storage SHALL be a sub-module arb_out_queue_ram (DEPTH x entry, one sync write port, one async read port, async active-low clear).

Verification
REQ-030 After reset release: io_enq_ready=1, io_deq_valid=0, io_count=0, io_deq_bits=0.
REQ-031 Enqueue 0x11/src0, 0x22/src1, 0x33/src2, 0x44/src3 with deq_ready=0 -> io_count=4, io_enq_ready=0; 5th enq 0x55 ignored; then deq_ready=1 -> outputs 0x11/0,0x22/1,0x33/2,0x44/3, then deq_valid=0.
REQ-032 Hold count=2, drive enq and deq fire every cycle for 10 cycles (pointer wrap twice) -> io_count stays 2, data order preserved.
REQ-033 Full queue, deq_ready=1 and enq_valid=1 same cycle -> enq refused (ready=0), count becomes 3; next cycle enq accepted.
REQ-034 Empty queue, enq 0xA5/src2 with deq_ready=1 -> FLOW_EN: deq_valid=1, bits 0xA5, count 0 same cycle; no FLOW_EN: deq_valid=0 that cycle, 0xA5/2 at head next cycle.
REQ-035 Assert reset with count=3 -> outputs return to REQ-024 values immediately, before next clk edge.
